// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: shared state encoding and default sizes for the latch write sequencer
package latch_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, OPEN = 2'd2, HOLD = 2'd3} state_e;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NREQ]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: arbitrates requesters and drives a latch bank with SETUP/OPEN/HOLD
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*AW-1:0]    ReqAddr,
  input  logic [NREQ*WIDTH-1:0] ReqData,
  output logic [NREQ-1:0]       Grant,
  output logic [NREQ-1:0]       Ack,
  output logic [DEPTH-1:0]      LatchEn,
  output logic [WIDTH-1:0]      LatchD,
  output logic                  Busy
);
  localparam int IW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic [NREQ-1:0] win_gnt, grant_q, grant_d, ack_q, ack_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0] en_q, en_d, dec;
  logic busy_q, busy_d;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i(Req),
    .ptr_i(ptr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx)
  );
  // out-of-range addresses match no bit, so the bank is left untouched
  for (genvar g = 0; g < DEPTH; g++) begin : g_dec
    assign dec[g] = addr_q == AW'(g);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    addr_d = addr_q;
    data_d = data_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: if (|Req) begin
        state_d = SETUP;
        idx_d = win_idx;
        grant_d = win_gnt;
        addr_d = ReqAddr[int'(win_idx)*AW +: AW];
        data_d = ReqData[int'(win_idx)*WIDTH +: WIDTH];
      end
      SETUP: state_d = OPEN;
      OPEN: state_d = HOLD;
      default: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
      end
    endcase
    en_d = (state_d == OPEN) ? dec : '0;
    ack_d = (state_d == HOLD) ? grant_q : '0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      en_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      data_q <= data_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      en_q <= en_d;
      busy_q <= busy_d;
    end
  end
  assign Grant = grant_q;
  assign Ack = ack_q;
  assign LatchEn = en_q;
  assign LatchD = data_q;
  assign Busy = busy_q;
endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: table vectors plus corner sequences, Ack-driven scoreboard
module tb_latch_write_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [3:0] Req = '0;
  logic [7:0] ReqAddr = '0;
  logic [31:0] ReqData = '0;
  logic [3:0] Grant, Ack, LatchEn, Grant3, Ack3;
  logic [2:0] LatchEn3;
  logic [7:0] LatchD, LatchD3;
  logic Busy, Busy3;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [31:0] data;
    logic [3:0] gnt;
    logic [3:0] en;
    logic [7:0] d;
  } vec_t;
  typedef struct {
    logic [3:0] gnt;
    logic [3:0] en;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[7];

  latch_write_sequencer #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Grant(Grant), .Ack(Ack), .LatchEn(LatchEn), .LatchD(LatchD), .Busy(Busy)
  );
  latch_write_sequencer #(.NREQ(4), .WIDTH(8), .DEPTH(3), .AW(2)) dut3 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Grant(Grant3), .Ack(Ack3), .LatchEn(LatchEn3), .LatchD(LatchD3), .Busy(Busy3)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] e, input logic [7:0] d);
    exp_t x;
    x.gnt = g;
    x.en = e;
    x.d = d;
    sb.push_back(x);
  endtask

  // monitor samples 2 time units after each edge; stimulus changes 1 unit after
  initial begin
    logic rs;
    logic [3:0] seen_en, prev_en;
    logic [7:0] prev_d;
    exp_t e;
    seen_en = '0;
    prev_en = '0;
    prev_d = '0;
    forever begin
      @(posedge Clk);
      rs = Reset;
      #2;
      if (rs) seen_en = '0;
      else begin
        chk("en_multi_hot", 32'($countones(LatchEn) > 1), 0);
        chk("en3_multi_hot", 32'($countones(LatchEn3) > 1), 0);
        if (LatchEn != 0) begin
          seen_en = LatchEn;
          chk("d_stable_before_open", LatchD, prev_d);
        end
        if (prev_en != 0 && LatchEn == 0) chk("d_stable_after_close", LatchD, prev_d);
        if (Ack != 0) begin
          if (sb.size() == 0) chk("ack_unexpected", Ack, 0);
          else begin
            e = sb.pop_front();
            chk("sb_ack", Ack, e.gnt);
            chk("sb_data", LatchD, e.d);
            chk("sb_en", seen_en, e.en);
          end
          seen_en = '0;
        end
      end
      prev_en = LatchEn;
      prev_d = LatchD;
    end
  end

  initial begin
    vecs[0] = '{4'b0001, 8'hE4, 32'h44332211, 4'b0001, 4'b0001, 8'h11};
    vecs[1] = '{4'b1001, 8'hE4, 32'h88776655, 4'b1000, 4'b1000, 8'h88};
    vecs[2] = '{4'b1001, 8'h1B, 32'hDDCCBBAA, 4'b0001, 4'b1000, 8'hAA};
    vecs[3] = '{4'b0110, 8'h1B, 32'h0F1E2D3C, 4'b0010, 4'b0100, 8'h2D};
    vecs[4] = '{4'b0011, 8'h1B, 32'hF0E1D2C3, 4'b0001, 4'b1000, 8'hC3};
    vecs[5] = '{4'b0100, 8'h1B, 32'h5A6B7C8D, 4'b0100, 4'b0010, 8'h6B};
    vecs[6] = '{4'b0111, 8'hE4, 32'h01020304, 4'b0001, 4'b0001, 8'h04};
    step();
    step();
    chk("rst_grant", Grant, 0);
    chk("rst_ack", Ack, 0);
    chk("rst_en", LatchEn, 0);
    chk("rst_d", LatchD, 0);
    chk("rst_busy", Busy, 0);
    // single write: requester 0, address 2, data A5
    Reset = 1'b0;
    Req = 4'b0001;
    ReqAddr = 8'h02;
    ReqData = 32'h000000A5;
    push(4'b0001, 4'b0100, 8'hA5);
    step();
    chk("p1_setup_d", LatchD, 8'hA5);
    chk("p1_setup_busy", Busy, 1);
    chk("p1_setup_grant", Grant, 4'b0001);
    chk("p1_setup_en", LatchEn, 0);
    step();
    chk("p1_open_en", LatchEn, 4'b0100);
    step();
    chk("p1_hold_en", LatchEn, 0);
    chk("p1_hold_ack", Ack, 4'b0001);
    Req = '0;
    step();
    chk("p1_idle_busy", Busy, 0);
    chk("p1_idle_ack", Ack, 0);
    chk("p1_idle_grant", Grant, 0);
    // table-driven arbitration and addressing
    for (int v = 0; v < 7; v++) begin
      Req = vecs[v].req;
      ReqAddr = vecs[v].addr;
      ReqData = vecs[v].data;
      push(vecs[v].gnt, vecs[v].en, vecs[v].d);
      step();
      chk($sformatf("v%0d_grant", v), Grant, vecs[v].gnt);
      chk($sformatf("v%0d_d", v), LatchD, vecs[v].d);
      chk($sformatf("v%0d_busy", v), Busy, 1);
      step();
      chk($sformatf("v%0d_en", v), LatchEn, vecs[v].en);
      step();
      Req = '0;
      step();
      chk($sformatf("v%0d_idle", v), {Busy, Grant}, 0);
    end
    // all requesters held: strict rotation, one SETUP every 4 cycles
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Req = 4'b1111;
    ReqAddr = 8'hE4;
    ReqData = 32'h44332211;
    push(4'b0001, 4'b0001, 8'h11);
    push(4'b0010, 4'b0010, 8'h22);
    push(4'b0100, 4'b0100, 8'h33);
    push(4'b1000, 4'b1000, 8'h44);
    push(4'b0001, 4'b0001, 8'h11);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] g;
      g = 4'b0001 << (i % 4);
      step();
      chk($sformatf("rr%0d_grant", i), Grant, g);
      if (i < 4) begin
        step();
        step();
        step();
      end
    end
    Req = '0;
    step();
    step();
    step();
    chk("rr_idle_busy", Busy, 0);
    // requester 2 arrives during requester 0's OPEN
    Req = 4'b0001;
    push(4'b0001, 4'b0001, 8'h11);
    step();
    chk("late_g0", Grant, 4'b0001);
    step();
    Req = 4'b0101;
    ReqData = 32'h44999999;
    push(4'b0100, 4'b0100, 8'h99);
    step();
    chk("late_d0_kept", LatchD, 8'h11);
    Req = 4'b0100;
    step();
    chk("late_gap", {Busy, Grant}, 0);
    step();
    chk("late_g2", Grant, 4'b0100);
    step();
    step();
    Req = '0;
    step();
    // reset in the middle of OPEN
    Req = 4'b1111;
    ReqData = 32'h44332211;
    step();
    chk("rmid_g3", Grant, 4'b1000);
    step();
    chk("rmid_open", LatchEn, 4'b1000);
    Reset = 1'b1;
    step();
    chk("rmid_en", LatchEn, 0);
    chk("rmid_grant", Grant, 0);
    chk("rmid_ack", Ack, 0);
    chk("rmid_d", LatchD, 0);
    chk("rmid_busy", Busy, 0);
    Reset = 1'b0;
    push(4'b0001, 4'b0001, 8'h11);
    step();
    chk("rmid_ptr0", Grant, 4'b0001);
    step();
    step();
    Req = '0;
    step();
    // address 3 on a 3-deep bank
    Req = 4'b0001;
    ReqAddr = 8'h03;
    ReqData = 32'h000000C6;
    push(4'b0001, 4'b1000, 8'hC6);
    step();
    chk("oob_setup_en3", LatchEn3, 0);
    chk("oob_grant3", Grant3, 4'b0001);
    step();
    chk("oob_open_en3", LatchEn3, 0);
    chk("oob_open_en4", LatchEn, 4'b1000);
    step();
    chk("oob_ack3", Ack3, 4'b0001);
    chk("oob_hold_en3", LatchEn3, 0);
    Req = '0;
    step();
    chk("oob_busy3", Busy3, 0);
    step();
    step();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Sequences write access to a bank of level-sensitive D latches and shares it between several requesters. Round-robin arbitration picks one requester, captures its address/data, then drives the latch bank with a fixed SETUP → OPEN → HOLD sequence. The sequence keeps each latch's enable high for exactly one clock, with data stable one cycle before and one cycle after. The block sits between requester logic and a latch-based register bank; the latches' own async reset is driven separately.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, latch word width
- DEPTH, 4, number of latch words
- AW, 2, address width, $clog2(DEPTH)

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous active-high reset
- Req  in  NREQ  per-requester write request, level
- ReqAddr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- ReqData  in  NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
- Grant  out  NREQ  one-hot, requester owning current transaction
- Ack  out  NREQ  one-cycle pulse, write to that requester completed
- LatchEn  out  DEPTH  one-hot latch enables to bank (high = transparent)
- LatchD  out  WIDTH  shared data bus to all latch D inputs
- Busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD. Transitions IDLE→SETUP (any Req), SETUP→OPEN, OPEN→HOLD, HOLD→IDLE (unconditional).
- IDLE: if Req ≠ 0, select winner via round-robin starting at pointer `ptr` (search ptr, ptr+1, … wrapping mod NREQ). Capture winner's ReqAddr/ReqData into internal registers and set Grant.
- SETUP: LatchD = captured data, LatchEn = 0.
- OPEN: LatchEn[captured addr] = 1, all other bits 0.
- HOLD: LatchEn = 0, LatchD unchanged, Ack[winner] = 1. `ptr` ← (winner+1) mod NREQ.
- Back in IDLE: Grant = 0, Ack = 0. LatchD holds its last value; it changes only on the next capture.
- Requesters hold Req until Ack. Req still high in the IDLE cycle after Ack counts as a new request.
- Req dropped mid-transaction: the transaction completes with the captured values. Ack still pulses.
- ReqAddr/ReqData changes after capture are ignored.
- Address ≥ DEPTH: no LatchEn bit asserted. The sequence and Ack proceed normally.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (sampled at an edge) overrides everything at that edge, including mid-OPEN. Result: state = IDLE, ptr = 0, Grant = 0, Ack = 0, LatchEn = 0, LatchD = 0, Busy = 0. An interrupted transaction is not Acked.

## Timing
- Req sampled high in IDLE at edge k:
  - edge k+1: SETUP, Grant, LatchD valid, Busy = 1
  - edge k+2: OPEN, LatchEn high
  - edge k+3: HOLD, LatchEn low, Ack high
  - edge k+4: IDLE, Grant/Ack/Busy low
- Throughput: one write per 4 cycles. Back-to-back requests give the next SETUP at k+5.
- Guarantees: LatchEn high exactly 1 cycle. LatchD stable ≥1 cycle before the LatchEn rise and ≥1 cycle after its fall. At most one LatchEn bit high at any time.

## Structure
- Package latch_seq_pkg:
  - state typedef (IDLE = 2'd0, SETUP = 2'd1, OPEN = 2'd2, HOLD = 2'd3)
  - default parameter constants
- Sub-module rr_arbiter: combinational, inputs Req[NREQ] and ptr, outputs one-hot winner and its index. Reusable elsewhere.
- Top level: FSM, capture registers, ptr register, output registers.

## Test plan
- Reset, then Req = 0001, ReqAddr0 = 2, ReqData0 = 8'hA5:
  - LatchD = A5 at k+1
  - LatchEn = 0100 for exactly one cycle at k+2
  - Ack = 0001 at k+3
  - Busy low at k+4
- All Req = 1111 held continuously: grants cycle 0→1→2→3→0, each 4 cycles apart. No requester is granted twice before all others.
- Req0 high with Req2 raised during Req0's OPEN: Req2 is granted at the SETUP immediately after Req0's HOLD→IDLE. Req0's data is unaffected by ReqData2.
- Reset asserted during OPEN: next edge LatchEn = 0, Grant = 0, Ack never pulses, LatchD = 0, ptr = 0 (Req = 1111 then grants requester 0).
- ReqAddr = 3 with DEPTH = 3: LatchEn stays 000 throughout. Ack still pulses at k+3.
- Checker over all runs:
  - LatchEn popcount ≤ 1 at all times
  - LatchD stable from one cycle before LatchEn rises to one cycle after it falls
